// File: rtl/router_arb_pkg.sv
// Shared definitions for the router output-port arbiter: default sizes,
// the output-register state type and the modulo index helper.
package router_arb_pkg;

   localparam int N_IN_DEF    = 5;
   localparam int PCKG_SZ_DEF = 40;

   // EMPTY: output register free; HOLD: output register holds a packet.
   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } arb_state_t;

   // Increment an input index with wrap-around at n.
   function automatic int next_idx(input int ptr, input int n = N_IN_DEF);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: starting just after rr_ptr, selects the
// first requesting input, wrapping modulo N_IN.
module rr_pick
   import router_arb_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int IDX_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]  req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N_IN-1:0]  gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any_req
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Scan rr_ptr+1, rr_ptr+2, ... and keep the first requester found.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves a
      // value unassigned, which would otherwise infer a latch.
      gnt      = '0;
      idx      = '0;
      any_req  = 1'b0;
      cand     = int'(rr_ptr);
      cand_idx = rr_ptr;
      for (int k = 0; k < N_IN; k++) begin
         cand     = next_idx(cand, N_IN);
         cand_idx = IDX_W'(cand);
         if (!any_req && req[cand_idx]) begin
            any_req       = 1'b1;
            gnt[cand_idx] = 1'b1;
            idx           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/router_port_arbiter.sv
// Round-robin arbiter sharing one mesh router output link among N_IN input
// FIFOs through a single-entry output register.
module router_port_arbiter
   import router_arb_pkg::*;
#(
   parameter int N_IN    = N_IN_DEF,
   parameter int pckg_sz = PCKG_SZ_DEF,
   parameter int IDX_W   = $clog2(N_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_IN-1:0]         en_mask,
   input  logic [N_IN-1:0]         pndng,
   input  logic [N_IN*pckg_sz-1:0] data_in,
   output logic [N_IN-1:0]         pop,
   output logic [pckg_sz-1:0]      out_data,
   output logic                    out_push,
   input  logic                    out_full,
   output logic [IDX_W-1:0]        grant_id,
   output logic                    out_valid
);

   // Pointer starts at the last input so input 0 wins first after reset.
   localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_IN - 1);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [IDX_W-1:0] rr_ptr;
   logic [N_IN-1:0]  req;
   logic [N_IN-1:0]  gnt;
   logic [IDX_W-1:0] win_idx;
   logic             any_req;
   logic             can_take;
   logic             grant;

   assign req = pndng & en_mask;

   rr_pick #(
      .N_IN  (N_IN),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .gnt     (gnt),
      .idx     (win_idx),
      .any_req (any_req)
   );

   // The register can accept when empty or when its packet drains this cycle.
   assign can_take = (state == EMPTY) || !out_full;
   // Qualified by reset so no pop escapes while reset is held.
   assign grant    = reset && can_take && any_req;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (!reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: fill on grant, empty on drain without a new grant.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (grant) state_nxt = HOLD;
         HOLD:    if (!out_full && !grant) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // Output decode: register status, push strobe and one-hot pop.
   always_comb begin
      out_valid = (state == HOLD);
      out_push  = (state == HOLD) && !out_full;
      pop       = grant ? gnt : '0;
   end

   // Output register and round-robin pointer, loaded on every grant.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: out_data is reset too, so downstream never observes stale
      // contents of a packet discarded by reset.
      if (!reset) begin
         out_data <= '0;
         grant_id <= '0;
         rr_ptr   <= PTR_RST;
      end else if (grant) begin
         out_data <= data_in[win_idx*pckg_sz +: pckg_sz];
         grant_id <= win_idx;
         rr_ptr   <= win_idx;
      end
   end

endmodule

// File: tb/tb_router_port_arbiter.sv
// Self-checking bench for router_port_arbiter: a behavioural model of the
// output register and round-robin order, a per-cycle compare process, and
// directed scenarios with literal expectations followed by random traffic.
module tb_router_port_arbiter;

   localparam int N  = 5;
   localparam int PW = 40;
   localparam int IW = 3;

   logic            clk      = 1'b0;
   logic            reset    = 1'b0;
   logic [N-1:0]    en_mask  = '0;
   logic [N-1:0]    pndng    = '0;
   logic [N*PW-1:0] data_in  = '0;
   logic            out_full = 1'b0;
   logic [N-1:0]    pop;
   logic [PW-1:0]   out_data;
   logic            out_push;
   logic [IW-1:0]   grant_id;
   logic            out_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   router_port_arbiter #(
      .N_IN    (N),
      .pckg_sz (PW),
      .IDX_W   (IW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en_mask   (en_mask),
      .pndng     (pndng),
      .data_in   (data_in),
      .pop       (pop),
      .out_data  (out_data),
      .out_push  (out_push),
      .out_full  (out_full),
      .grant_id  (grant_id),
      .out_valid (out_valid)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic          m_valid = 1'b0;
   logic [PW-1:0] m_data  = '0;
   int            m_gid   = 0;
   int            m_ptr   = N - 1;
   int            m_w;

   // First requester strictly after ptr, wrapping; -1 when nobody requests.
   function automatic int winner(input logic [N-1:0] r, input int ptr);
      for (int k = 1; k <= N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   assign m_w = winner(pndng & en_mask, m_ptr);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_gid   <= 0;
         m_ptr   <= N - 1;
      end else if (!m_valid || !out_full) begin
         if (m_w >= 0) begin
            m_valid <= 1'b1;
            m_data  <= data_in[m_w*PW +: PW];
            m_gid   <= m_w;
            m_ptr   <= m_w;
         end else begin
            m_valid <= 1'b0;
         end
      end
   end

   // Compare DUT outputs with the model every cycle, mid-period.
   always @(negedge clk) begin
      check("pop", pop,
            (reset && (!m_valid || !out_full) && m_w >= 0) ? (64'd1 << m_w) : 64'd0);
      check("out_valid", out_valid, m_valid);
      check("out_push", out_push, m_valid && !out_full);
      check("out_data", out_data, m_data);
      check("grant_id", grant_id, m_gid);
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      pndng    = '0;
      en_mask  = '1;
      out_full = 1'b0;
      repeat (2) cyc();
      reset = 1'b1;
   endtask

   int  seq2[7] = '{0, 1, 2, 3, 4, 0, 1};
   int  seq4[6] = '{0, 2, 4, 0, 2, 4};
   logic seen;

   initial begin
      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 40'h0);
      check("rst_gid", grant_id, 3'd0);

      // 1: single input 2
      cyc();
      pndng = 5'b00100;
      data_in[2*PW +: PW] = 40'hAA_0000_0001;
      @(negedge clk);
      check("t1_pop", pop, 5'b00100);
      cyc();
      pndng = '0;
      @(negedge clk);
      check("t1_valid", out_valid, 1'b1);
      check("t1_push", out_push, 1'b1);
      check("t1_data", out_data, 40'hAA_0000_0001);
      check("t1_gid", grant_id, 3'd2);

      // 2: all pending, rotation from reset
      cyc();
      do_reset();
      pndng = '1;
      @(negedge clk);
      check("t2_onehot", $onehot(pop), 1'b1);
      for (int k = 0; k < 7; k++) begin
         cyc();
         @(negedge clk);
         check("t2_gid", grant_id, seq2[k]);
         check("t2_onehot", $onehot(pop), 1'b1);
      end

      // 3: stall for 4 cycles with two packets
      cyc();
      do_reset();
      data_in[0*PW +: PW] = 40'h11_2233_4455;
      data_in[1*PW +: PW] = 40'h66_7788_99AA;
      pndng = 5'b00011;
      @(negedge clk);
      check("t3_pop0", pop, 5'b00001);
      cyc();
      pndng    = 5'b00010;
      out_full = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t3_hold_data", out_data, 40'h11_2233_4455);
         check("t3_hold_pop", pop, 5'b00000);
         check("t3_hold_push", out_push, 1'b0);
         cyc();
      end
      out_full = 1'b0;
      @(negedge clk);
      check("t3_rel_push", out_push, 1'b1);
      check("t3_rel_pop", pop, 5'b00010);
      cyc();
      pndng = '0;
      @(negedge clk);
      check("t3_next_data", out_data, 40'h66_7788_99AA);
      check("t3_next_gid", grant_id, 3'd1);

      // 4: masked rotation, then unmask input 1
      cyc();
      do_reset();
      pndng   = '1;
      en_mask = 5'b10101;
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         cyc();
         @(negedge clk);
         check("t4_gid", grant_id, seq4[k]);
      end
      cyc();
      en_mask = '1;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (pop[1]) seen = 1'b1;
         cyc();
      end
      check("t4_unmask_grant", seen, 1'b1);

      // 5: reset while holding and stalled
      do_reset();
      pndng    = 5'b00001;
      out_full = 1'b1;
      @(negedge clk);
      cyc();
      @(negedge clk);
      check("t5_held", out_valid, 1'b1);
      check("t5_stall_pop", pop, 5'b00000);
      cyc();
      reset = 1'b0;
      #1;
      check("t5_rst_valid", out_valid, 1'b0);
      check("t5_rst_pop", pop, 5'b00000);
      cyc();
      reset    = 1'b1;
      pndng    = 5'b01000;
      out_full = 1'b0;
      @(negedge clk);
      check("t5_first3", pop, 5'b01000);
      cyc();
      do_reset();
      pndng = 5'b01001;
      @(negedge clk);
      check("t5_first0", pop, 5'b00001);

      // 6: idle after drain keeps pointer
      cyc();
      do_reset();
      pndng = 5'b00100;
      @(negedge clk);
      cyc();
      pndng = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("t6_pop", pop, 5'b00000);
         if (k > 0) begin
            check("t6_valid", out_valid, 1'b0);
            check("t6_push", out_push, 1'b0);
         end
         cyc();
      end
      pndng = '1;
      @(negedge clk);
      check("t6_resume", pop, 5'b01000);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cyc();
         reset    = ($urandom_range(0, 299) != 0);
         pndng    = N'($urandom);
         en_mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
         out_full = ($urandom_range(0, 2) == 0);
         for (int j = 0; j < N; j++) data_in[j*PW +: PW] = PW'({$urandom, $urandom});
      end
      cyc();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/router_port_arbiter.md
Name: router_port_arbiter

Overview:
- Round-robin arbiter that shares one mesh router output link among N_IN input FIFOs (N, S, E, W, local terminal).
- Sits between the per-input FIFO heads (pndng/data_out/pop handshake) and the downstream output FIFO (push/full handshake) of a mesh_gnrtr node.
- Moves single-flit packets of pckg_sz bits through a one-entry output register.
- Sustains one packet per cycle when the downstream FIFO is not full.

Parameters:
- N_IN, 5: number of requesting inputs.
- pckg_sz, 40: packet width in bits.
- IDX_W, $clog2(N_IN): grant index width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en_mask  input  N_IN  per-input enable; 0 excludes that input from arbitration.
- pndng  input  N_IN  input FIFO non-empty; head flit valid on data_in.
- data_in  input  N_IN*pckg_sz  FIFO heads; input i occupies bits [i*pckg_sz +: pckg_sz].
- pop  output  N_IN  one-hot pop to the winning input FIFO (combinational).
- out_data  output  pckg_sz  registered packet toward the downstream FIFO.
- out_push  output  1  push strobe, equal to out_valid & !out_full.
- out_full  input  1  downstream FIFO full.
- grant_id  output  IDX_W  index of the input that supplied the packet held in out_data.
- out_valid  output  1  output register holds a packet.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, out_data=0, grant_id=0.
  - Round-robin pointer rr_ptr=N_IN-1, so input 0 has first priority.
  - pop=0 and out_push=0 while reset is asserted.
- Eligibility: req[i] = pndng[i] & en_mask[i].
- Accept condition: can_take = !out_valid | (out_valid & !out_full). The output register is empty, or it is draining this cycle.
- Winner: the first eligible index found searching rr_ptr+1, rr_ptr+2, ... with wrap-around modulo N_IN. This is a pure function of req and rr_ptr.
- When can_take and |req, in the same cycle:
  - pop[w]=1 (exactly one bit).
  - At the next edge: out_data<=data_in[w], grant_id<=w, out_valid<=1, rr_ptr<=w.
- When can_take and no request: pop=0. At the next edge out_valid<=0 if it drained, otherwise it stays 0. rr_ptr is unchanged.
- When !can_take (out_valid=1 and out_full=1):
  - pop=0.
  - out_data, grant_id and rr_ptr hold.
  - out_push=0.
- FSM has two states:
  - EMPTY (out_valid=0).
  - HOLD (out_valid=1).
  - Transitions:
    - EMPTY->HOLD on a grant.
    - HOLD->HOLD on drain plus grant, or on stall.
    - HOLD->EMPTY on drain with no grant.
- Latency: pop in cycle t gives out_valid/out_data in t+1, with out_push in t+1 if !out_full.
- Fairness: with all inputs requesting continuously and no stall, grants rotate 0,1,...,N_IN-1,0. No input waits more than N_IN-1 grants.
- en_mask changes take effect the same cycle. Masking the current holder never drops the registered packet.
- pndng dropping in the same cycle as a grant: pop is computed from the current pndng, so a popped input was pending that cycle.
- Data is transferred unmodified; no field decoding, including broadcast ids.
- Reset mid-operation discards a held packet. No pop is issued during reset.

Decomposition:
- Package router_arb_pkg holds:
  - default N_IN and pckg_sz;
  - the arb_state_t enum {EMPTY, HOLD};
  - the function next_idx(ptr) for modulo-N_IN increment.
- Sub-module rr_pick: combinational round-robin picker. Inputs req and rr_ptr; outputs one-hot gnt, encoded idx and any_req.
- router_port_arbiter contains the FSM, the output register and the pointer.

Test Plan:
1. Only input 2 pending, data 40'hAA_0000_0001, out_full=0 -> pop=5'b00100 at t, out_valid=1 and out_push=1 at t+1, out_data=40'hAA_0000_0001, grant_id=2.
2. All 5 pending continuously from reset, out_full=0 -> grant_id sequence 0,1,2,3,4,0,1 on consecutive cycles; pop is one-hot every cycle.
3. Two packets in flight, out_full=1 for 4 cycles after the first grant -> out_data held, pop=0 and out_push=0 for 4 cycles. On release, the held packet is pushed and the next grant is popped in the same cycle.
4. All pending, en_mask=5'b10101 -> grants cycle only 0,2,4. Setting mask bit 1 mid-stream -> input 1 is granted within 4 cycles.
5. reset asserted (low) while out_valid=1 and out_full=1 -> out_valid=0 and pop=0 immediately. After release with input 3 pending, the first grant goes to input 0 if pending, else to 3.
6. No input pending for 10 cycles after a drain -> out_valid=0, out_push=0, pop=0, and rr_ptr unchanged, so the next grant follows the last winner.
